// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_ALIGN_CHK_EN (fetch_unit) turns odd redirect targets into a sticky error.
package fetch_pkg;

  localparam int INST_W = 16;
  localparam int PC_W   = 16;

  localparam logic [PC_W-1:0]   PC_INC     = 16'd2;
  localparam logic [PC_W-1:0]   ALIGN_MASK = 16'hFFFE;
  localparam logic [INST_W-1:0] NOP_INST   = 16'h0800;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_VALID,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its incrementer and next-PC select.
// Redirect targets are always word aligned before being loaded.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            redirect,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc
);

  logic [PC_W-1:0] next_pc;

  // The adder wraps naturally at 16 bits, so 16'hFFFE steps to 16'h0000.
  assign pc_inc  = pc + PC_INC;
  assign next_pc = redirect ? (target & ALIGN_MASK) : pc_inc;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/VALID/HALTED control around a PC register.
// Define FETCH_ALIGN_CHK_EN to halt with err on an odd redirect target.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc_plus2,
  input  logic              dec_ready,
  input  logic              halt_in,
  input  logic              dec_err,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halted,
  output logic              err
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_inc;
  logic             accept;
  logic             misalign;
  logic             stop;
  logic             pc_load;

  assign accept = (state == ST_VALID) && dec_ready;

`ifdef FETCH_ALIGN_CHK_EN
  assign misalign = redirect & redirect_pc[0];
`else
  assign misalign = 1'b0;
`endif

  assign stop    = halt_in | dec_err | misalign;
  assign pc_load = accept & ~stop;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .redirect (redirect),
    .target   (redirect_pc),
    .pc       (pc),
    .pc_inc   (pc_inc)
  );

  assign imem_addr = pc;

  // imem_req stays low for the first FETCH cycle after reset, so a late
  // completion from an abandoned request can never be captured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_FETCH;
      wait_cnt   <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
      pc_plus2   <= '0;
      halted     <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            inst       <= imem_rdata;
            pc_plus2   <= pc_inc;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
            state      <= ST_VALID;
          end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
            imem_req <= 1'b0;
            err      <= 1'b1;
            halted   <= 1'b1;
            state    <= ST_HALTED;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_VALID: begin
          if (dec_ready) begin
            inst_valid <= 1'b0;
            if (stop) begin
              // halt_in outranks the redirect, so it masks an alignment fault.
              err    <= err | dec_err | (misalign & ~halt_in);
              halted <= 1'b1;
              state  <= ST_HALTED;
            end else begin
              wait_cnt <= '0;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          halted     <= 1'b1;
          state      <= ST_HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC-level model queues expected fetches,
// a monitor checks every request and every presented instruction.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          WAIT_MAX = 15;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] pc_plus2;
  logic        dec_ready = 1'b0;
  logic        halt_in = 1'b0;
  logic        dec_err = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;
  logic        err;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .pc_plus2    (pc_plus2),
    .dec_ready   (dec_ready),
    .halt_in     (halt_in),
    .dec_err     (dec_err),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: program image, architectural PC and expected fetch stream.
  logic [15:0] m_pc;
  bit          m_halted;
  bit          m_err;
  logic [15:0] addr_q[$];
  logic [31:0] inst_q[$];
  int          accepts = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h4001;
    return (a ^ 16'hB5A3) + {a[7:0], a[15:8]};
  endfunction

  function automatic void expect_fetch(input logic [15:0] a);
    addr_q.push_back(a);
    inst_q.push_back({mem_word(a), a + 16'd2});
  endfunction

  // Memory responder: per-request latency, spurious strobes while idle.
  int mem_delay = 0;
  bit mem_never = 1'b0;
  bit pending   = 1'b0;
  int wait_left = 0;

  initial begin
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!imem_req) begin
        pending    = 1'b0;
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = 16'($urandom);
      end else begin
        if (!pending) begin
          pending   = 1'b1;
          wait_left = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        end
        if (!mem_never && wait_left == 0) begin
          imem_ready = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end else begin
          imem_ready = 1'b0;
          imem_rdata = 16'($urandom);
          if (wait_left > 0) wait_left--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each new request and each new instruction.
  logic [15:0] cur_addr = 16'h0000;
  logic [31:0] cur_inst = 32'h0;
  bit          prev_req = 1'b0;
  bit          prev_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (!prev_req) begin
          check("request_expected", 32'(addr_q.size() != 0), 32'd1);
          if (addr_q.size() != 0) begin
            cur_addr = addr_q.pop_front();
            check("fetch_addr", 32'(imem_addr), 32'(cur_addr));
          end
        end else begin
          check("fetch_addr_hold", 32'(imem_addr), 32'(cur_addr));
        end
      end
      if (inst_valid) begin
        if (!prev_valid) begin
          check("inst_expected", 32'(inst_q.size() != 0), 32'd1);
          if (inst_q.size() != 0) begin
            cur_inst = inst_q.pop_front();
            check("inst", 32'(inst), 32'(cur_inst[31:16]));
            check("pc_plus2", 32'(pc_plus2), 32'(cur_inst[15:0]));
          end
        end else begin
          check("inst_hold", {inst, pc_plus2}, cur_inst);
        end
      end
      prev_req   = imem_req;
      prev_valid = inst_valid;
    end
  end

  // Drive decoder inputs for one cycle; the model advances on acceptance.
  task automatic step(input bit rdy, input bit hlt, input bit derr, input bit rdr,
                      input logic [15:0] tgt);
    dec_ready   = rdy;
    halt_in     = hlt;
    dec_err     = derr;
    redirect    = rdr;
    redirect_pc = tgt;
    if (rst && inst_valid && rdy && !m_halted) begin
      accepts++;
      if (hlt || derr) begin
        m_halted = 1'b1;
        m_err    = m_err | derr;
      end else if (ALIGN_CHK && rdr && tgt[0]) begin
        m_halted = 1'b1;
        m_err    = 1'b1;
      end else begin
        m_pc = rdr ? (tgt & 16'hFFFE) : m_pc + 16'd2;
        expect_fetch(m_pc);
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_step();
    bit          rdy  = ($urandom_range(0, 3) != 0);
    bit          rdr  = ($urandom_range(0, 2) == 0);
    bit          hlt  = 1'($urandom_range(0, 1));
    bit          derr = 1'($urandom_range(0, 1));
    logic [15:0] tgt  = 16'($urandom);
    if (inst_valid && rdy) begin
      hlt  = 1'b0;
      derr = 1'b0;
      if (ALIGN_CHK) tgt[0] = 1'b0;
    end
    step(rdy, hlt, derr, rdr, tgt);
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b0;
    m_pc     = RESET_PC;
    m_halted = 1'b0;
    m_err    = 1'b0;
    addr_q.delete();
    inst_q.delete();
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic release_reset();
    expect_fetch(RESET_PC);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 40 && !inst_valid; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check(name, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1);
  end

  initial begin
    int lat;
    int nreq;
    int acc0;

    @(negedge clk);
    do_reset(3);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_nop", 32'(inst), 32'h0800);
    check("rst_pc_plus2", 32'(pc_plus2), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // First fetch latency, then zero-wait throughput.
    mem_delay = 0;
    release_reset();
    lat = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      if (k == 1) check("req_after_release", 32'(imem_req), 32'd1);
      if (inst_valid) lat = k;
    end
    check("first_valid_latency", 32'(lat), 32'd2);
    acc0 = accepts;
    repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("throughput_20_cycles", 32'(accepts - acc0), 32'd10);

    // Memory wait of three cycles.
    mem_delay = 3;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    nreq = 0;
    for (int k = 0; k < 20 && !inst_valid; k++) begin
      if (imem_req) nreq++;
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    check("wait_req_cycles", 32'(nreq), 32'd4);
    check("err_after_wait", 32'(err), 32'd0);
    mem_delay = 0;

    // Decoder stall with noisy control inputs, then redirect.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0101);
      check("stall_no_request", 32'(imem_req), 32'd0);
    end
    check("stall_not_halted", 32'(halted), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0040);
    wait_valid("valid_after_redirect");

    // PC wrap from 16'hFFFE.
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE);
    wait_valid("valid_at_fffe");
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    wait_valid("valid_after_wrap");
    check("err_after_wrap", 32'(err), 32'd0);

    // Randomised traffic.
    mem_delay = -1;
    acc0 = accepts;
    for (int k = 0; k < 3000 && (accepts - acc0) < 150; k++) rand_step();
    check("random_accepts", 32'((accepts - acc0) >= 150), 32'd1);
    mem_delay = 0;
    wait_valid("valid_before_halt");

    // Halt wins over redirect; everything is ignored afterwards.
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
    check("halt_halted", 32'(halted), 32'(m_halted));
    check("halt_err", 32'(err), 32'(m_err));
    for (int k = 0; k < 8; k++) begin
      rand_step();
      check("halted_no_req", 32'(imem_req), 32'd0);
      check("halted_no_valid", 32'(inst_valid), 32'd0);
    end
    check("halted_stays", 32'(halted), 32'd1);

    // Memory never responds: timeout after WAIT_MAX request cycles.
    do_reset(1);
    mem_never = 1'b1;
    release_reset();
    nreq = 0;
    for (int k = 0; k < 40 && !halted; k++) begin
      if (imem_req) nreq++;
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    check("timeout_req_cycles", 32'(nreq), 32'(WAIT_MAX));
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_halted", 32'(halted), 32'd1);

    // One reset cycle clears the sticky error; then reset mid-wait.
    do_reset(1);
    check("reset_clears_err", 32'(err), 32'd0);
    check("reset_clears_halted", 32'(halted), 32'd0);
    release_reset();
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("mid_wait_requesting", 32'(imem_req), 32'd1);
    mem_never = 1'b0;
    do_reset(1);
    release_reset();
    wait_valid("valid_after_abandon");
    check("abandon_err", 32'(err), 32'd0);

    // Decoder error on acceptance.
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("dec_err_halted", 32'(halted), 32'd1);
    check("dec_err_err", 32'(err), 32'd1);

    // Odd redirect target.
    do_reset(1);
    release_reset();
    wait_valid("valid_before_odd");
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0041);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("odd_target_err", 32'(err), 32'(ALIGN_CHK));
    check("odd_target_halted", 32'(halted), 32'(ALIGN_CHK));
    check("odd_target_model", {31'd0, halted}, {31'd0, m_halted});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
